// File: rtl/iter_divider_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] MIN_INT    = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/iter_divider_universal_adder.sv
// Add/subtract unit: mode=1 computes a-b as a+~b+1; carry=1 means no borrow.
module universal_adder #(
  parameter int DATAWIDTH = 33
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 mode,
  output logic [DATAWIDTH-1:0] out,
  output logic                 carry,
  output logic                 overflow
);

  logic [DATAWIDTH-1:0] b_eff;

  assign b_eff          = mode ? ~b : b;
  assign {carry, out}   = {1'b0, a} + {1'b0, b_eff} + {{DATAWIDTH{1'b0}}, mode};
  assign overflow       = (a[DATAWIDTH-1] == b_eff[DATAWIDTH-1]) &&
                          (out[DATAWIDTH-1] != a[DATAWIDTH-1]);

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) with valid/ready handshakes on both sides.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int DATAWIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder
);

  localparam int CW = $clog2(DATAWIDTH);
  localparam logic [DATAWIDTH-1:0] ALL_ONES = {DATAWIDTH{1'b1}};
  localparam logic [DATAWIDTH-1:0] MIN_VAL  = {1'b1, {(DATAWIDTH-1){1'b0}}};
  localparam logic [CW-1:0]        LAST_CNT = CW'(DATAWIDTH - 1);

  div_state_t state, state_next;

  logic [CW-1:0]        counter;
  logic [DATAWIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
  logic [DATAWIDTH-1:0] rem;
  logic [DATAWIDTH-1:0] divisor;
  logic                 q_neg, r_neg;

  logic                 accept, a_neg, b_neg, div_zero, sig_ovf;
  logic [DATAWIDTH:0]   shifted, adder_out;
  logic                 adder_carry;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign a_neg     = is_signed && a[DATAWIDTH-1];
  assign b_neg     = is_signed && b[DATAWIDTH-1];
  assign div_zero  = (b == '0);
  assign sig_ovf   = is_signed && (a == MIN_VAL) && (b == ALL_ONES);
  assign shifted   = {rem, dvd[DATAWIDTH-1]};

  universal_adder #(.DATAWIDTH(DATAWIDTH + 1)) u_adder (
    .a        (shifted),
    .b        ({1'b0, divisor}),
    .mode     (1'b1),
    .out      (adder_out),
    .carry    (adder_carry),
    .overflow ()
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (div_zero || sig_ovf) ? DONE : CALC;
      CALC: if (counter == LAST_CNT) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      dvd       <= '0;
      rem       <= '0;
      divisor   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dvd     <= a_neg ? (~a + 1'b1) : a;
          divisor <= b_neg ? (~b + 1'b1) : b;
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
          rem     <= '0;
          counter <= '0;
          if (div_zero) begin
            quotient  <= ALL_ONES;
            remainder <= a;
          end else if (sig_ovf) begin
            quotient  <= MIN_VAL;
            remainder <= '0;
          end
        end
        CALC: begin
          rem     <= adder_carry ? adder_out[DATAWIDTH-1:0] : shifted[DATAWIDTH-1:0];
          dvd     <= {dvd[DATAWIDTH-2:0], adder_carry};
          counter <= counter + 1'b1;
        end
        FIX: begin
          quotient  <= q_neg ? (~dvd + 1'b1) : dvd;
          remainder <= r_neg ? (~rem + 1'b1) : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: scoreboard of expected {quotient,remainder} plus latency.
module tb_iter_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient, remainder;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             checks = 0;
  int             errors = 0;

  iter_divider #(.DATAWIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model written from the arithmetic definition, not from the datapath.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    lat = 34;
    if (y == 0) begin
      q = '1; r = x; lat = 1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; lat = 1;
    end else if (s) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation, collect its result, hold it for 'stall' cycles, then hand it off.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int stall);
    logic [W-1:0] eq, er;
    logic [2*W-1:0] ex;
    int el, lat;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    model(x, y, s, eq, er, el);
    exp_q.push_back({eq, er});
    lat_q.push_back(el);
    a = x; b = y; is_signed = s; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    ex = exp_q.pop_front();
    check("latency", 64'(lat), 64'(lat_q.pop_front()));
    check("quotient", 64'(quotient), 64'(ex[2*W-1:W]));
    check("remainder", 64'(remainder), 64'(ex[W-1:0]));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      check("in_ready_busy", 64'(in_ready), 64'd0);
      step();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_q", 64'(quotient), 64'(ex[2*W-1:W]));
      check("hold_r", 64'(remainder), 64'(ex[W-1:0]));
    end
    // in_valid stays high through the handshake cycle; it must not be taken.
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("valid_drop", 64'(out_valid), 64'd0);
    check("ready_after", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
    run_op(32'h1234_5678, 32'd0, 1'b0, 0);
    run_op(32'h1234_5678, 32'd0, 1'b1, 2);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'd12345, 32'd17, 1'b0, 5);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op(32'h8000_0000, 32'd1, 1'b1, 0);
    run_op(32'd5, 32'd9, 1'b1, 0);

    // Reset in the middle of a computation.
    a = 32'd1000; b = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_q", 64'(quotient), 64'd0);
    check("midrst_r", 64'(remainder), 64'd0);
    run_op(32'd9, 32'd3, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom >> $urandom_range(0, 31);
      run_op(x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
